// File: rtl/food_tracker_pkg.sv
// Shared game definitions for the pellet tracker: map geometry, BCD digit type,
// tracker FSM states and a saturating BCD adder.
package food_tracker_pkg;

    localparam int unsigned MAP_W      = 80;
    localparam int unsigned MAP_H      = 50;
    localparam int unsigned TILE_SHIFT = 4;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        IDLE  = 2'd1,
        READ  = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Four-digit BCD add; a carry out of the thousands digit pins the result at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input bcd_digit_t b);
        logic [15:0] r;
        logic [4:0]  s;
        logic        c;
        r = a;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[i*4 +: 4]} + {1'b0, ((i == 0) ? b : 4'd0)} + {4'd0, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*4 +: 4] = s[3:0];
        end
        return c ? 16'h9999 : r;
    endfunction

endpackage

// File: rtl/food_tracker_ram.sv
// Pellet map storage: display read port A, read-first read/write port B for the tracker.
module food_tracker_ram #(
    parameter int unsigned W  = 80,
    parameter int unsigned D  = 50,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] a_addr,
    output logic [W-1:0]  a_data,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [W-1:0]  b_wdata,
    output logic [W-1:0]  b_rdata
);

    localparam logic [AW-1:0] LAST_ROW = AW'(D - 1);

    logic [W-1:0] mem [D];

    // Port B: old contents are returned on a same-address write.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        b_rdata <= mem[b_addr];
    end

    // Port A: rows past the map read as empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data <= '0;
        end else begin
            a_data <= (a_addr <= LAST_ROW) ? mem[a_addr] : '0;
        end
    end

endmodule

// File: rtl/food_tracker.sv
// Pellet map owner: refills the map, clears the pellet under pacman via
// read-modify-write, and keeps the BCD score and pellets-remaining count.
module food_tracker #(
    parameter int unsigned MAP_W        = food_tracker_pkg::MAP_W,
    parameter int unsigned MAP_H        = food_tracker_pkg::MAP_H,
    parameter int unsigned TILE_SHIFT   = food_tracker_pkg::TILE_SHIFT,
    parameter int unsigned PELLET_TOTAL = 1400,
    parameter int unsigned POINTS       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       food_idx_y,
    output logic [MAP_W-1:0] food_row,
    input  logic [10:0]      pacman_blkpos_x,
    input  logic [9:0]       pacman_blkpos_y,
    input  logic             pos_valid,
    input  logic             restart,
    input  logic             next_level,
    output logic [15:0]      score,
    output logic [10:0]      pellets_left,
    output logic             level_clear,
    output logic             eat_pulse,
    output logic             busy
);
    import food_tracker_pkg::*;

    localparam int unsigned ROW_W = 6;
    localparam int unsigned COL_W = $clog2(MAP_W);

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic               pend_q, pend_d;
    logic [COL_W-1:0]   pend_x_q, pend_x_d, tx_q, tx_d;
    logic [ROW_W-1:0]   pend_y_q, pend_y_d, ty_q, ty_d;
    logic               eat_q, eat_d;
    logic               busy_q;
    logic [15:0]        score_q;
    logic [10:0]        pellets_q;
    logic               level_clear_q, eat_pulse_q;

    logic [11:0]        tile_x_full;
    logic [10:0]        tile_y_full;
    logic               pos_ok;
    logic               refill;
    logic [ROW_W-1:0]   b_addr;
    logic               b_we;
    logic [MAP_W-1:0]   b_wdata, b_rdata;

    // Tile under the sprite centre; off-map updates are ignored entirely.
    assign tile_x_full = (12'(pacman_blkpos_x) + 12'd8) >> TILE_SHIFT;
    assign tile_y_full = (11'(pacman_blkpos_y) + 11'd8) >> TILE_SHIFT;
    assign pos_ok      = pos_valid && (tile_x_full < 12'(MAP_W)) && (tile_y_full < 11'(MAP_H));
    assign refill      = restart || next_level;

    food_tracker_ram #(.W(MAP_W), .D(MAP_H), .AW(ROW_W)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_addr  (food_idx_y),
        .a_data  (food_row),
        .b_addr  (b_addr),
        .b_we    (b_we),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            pend_q     <= 1'b0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            eat_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            pend_q     <= pend_d;
            pend_x_q   <= pend_x_d;
            pend_y_q   <= pend_y_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            eat_q      <= eat_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        pend_d     = pend_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        eat_d      = 1'b0;
        b_addr     = ty_q;
        b_we       = 1'b0;
        b_wdata    = b_rdata;

        // Strobes arriving mid-operation park in pend; the newest one wins.
        if (state_q != IDLE && pos_ok) begin
            pend_d   = 1'b1;
            pend_x_d = COL_W'(tile_x_full);
            pend_y_d = ROW_W'(tile_y_full);
        end

        case (state_q)
            FILL: begin
                b_addr  = fill_cnt_q;
                b_we    = 1'b1;
                b_wdata = '1;
                if (fill_cnt_q == ROW_W'(MAP_H - 1)) begin
                    state_d = IDLE;
                end else begin
                    fill_cnt_d = fill_cnt_q + ROW_W'(1);
                end
            end
            IDLE: begin
                if (pos_ok) begin
                    tx_d    = COL_W'(tile_x_full);
                    ty_d    = ROW_W'(tile_y_full);
                    pend_d  = 1'b0;
                    state_d = READ;
                end else if (pend_q) begin
                    tx_d    = pend_x_q;
                    ty_d    = pend_y_q;
                    pend_d  = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
                if (b_rdata[tx_q]) begin
                    b_we    = 1'b1;
                    b_wdata = b_rdata & ~(MAP_W'(1) << tx_q);
                    eat_d   = 1'b1;
                end
            end
        endcase

        // A refill aborts whatever is in flight, including a pending write-back.
        if (refill) begin
            state_d    = FILL;
            fill_cnt_d = '0;
            pend_d     = 1'b0;
            b_we       = 1'b0;
            eat_d      = 1'b0;
        end
    end

    // Score and count follow the write-back by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q       <= '0;
            pellets_q     <= 11'(PELLET_TOTAL);
            level_clear_q <= 1'b0;
            eat_pulse_q   <= 1'b0;
        end else begin
            level_clear_q <= (pellets_q == 11'd0);
            eat_pulse_q   <= eat_q && !refill;
            if (restart) begin
                score_q   <= '0;
                pellets_q <= 11'(PELLET_TOTAL);
            end else if (next_level) begin
                pellets_q <= 11'(PELLET_TOTAL);
            end else if (eat_q) begin
                score_q <= bcd_add_sat(score_q, 4'(POINTS));
                if (pellets_q != 11'd0) begin
                    pellets_q <= pellets_q - 11'd1;
                end
            end
        end
    end

    assign score        = score_q;
    assign pellets_left = pellets_q;
    assign level_clear  = level_clear_q;
    assign eat_pulse    = eat_pulse_q;
    assign busy         = busy_q;

endmodule
